// File: rtl/mem_pkg.sv
// Shared types and helpers for the two-port synchronous memory.
// No latency or backpressure of its own.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int DEF_WORD_SIZE = 32;
    localparam int BYTES         = DEF_WORD_SIZE / 8;

    // be_merge works on the widest supported word; callers size-cast in and out.
    localparam int MAX_WORD  = 512;
    localparam int MAX_BYTES = MAX_WORD / 8;

    function automatic logic [MAX_WORD-1:0] be_merge(
        input logic [MAX_WORD-1:0]  old_word,
        input logic [MAX_WORD-1:0]  new_word,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WORD-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Clear engine: zeroes one word per cycle after reset or a clr request.
// MEM_SIZE cycles per sweep; ignores clr while sweeping, callers see busy.
module mem_clear_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_LEN = 5,
    parameter int MEM_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    output logic                busy,
    output logic                clr_we,
    output logic [ADDR_LEN-1:0] clr_addr
);

    localparam logic [ADDR_LEN-1:0] LAST = ADDR_LEN'(MEM_SIZE - 1);

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we   = 1'b0;
        clr_addr = cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_LEN'(1);
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // busy is a pure decode of the state flop, so it is glitch-free.
    assign busy = (state_q == CLEAR);

endmodule

// File: rtl/mem_2p_sync.sv
// Simple dual-port RAM: byte-enable write, registered read with valid, self-clearing.
// Read latency 1 cycle, one read per cycle; requests are dropped (not stalled) while busy.
module mem_2p_sync
    import mem_pkg::*;
#(
    parameter int ADDR_LEN  = 5,
    parameter int WORD_SIZE = 32,
    parameter int MEM_SIZE  = 32,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    output logic                   busy,
    input  logic                   r_en,
    input  logic [ADDR_LEN-1:0]    r_addr,
    output logic [WORD_SIZE-1:0]   data_out,
    output logic                   rd_valid,
    input  logic                   w_en,
    input  logic [ADDR_LEN-1:0]    w_addr,
    input  logic [WORD_SIZE/8-1:0] w_be,
    input  logic [WORD_SIZE-1:0]   data_in,
    output logic                   oob_err
);

    localparam logic [ADDR_LEN:0] LIMIT = (ADDR_LEN + 1)'(MEM_SIZE);

    logic [WORD_SIZE-1:0] mem [MEM_SIZE];

    logic                 busy_i;
    logic                 clr_we;
    logic [ADDR_LEN-1:0]  clr_addr;
    logic                 idle;
    logic                 r_in_range, w_in_range;
    logic                 r_acc, w_acc, w_ok;
    logic [WORD_SIZE-1:0] rd_old, wr_old, wr_word, rd_word;

    mem_clear_ctrl #(
        .ADDR_LEN (ADDR_LEN),
        .MEM_SIZE (MEM_SIZE)
    ) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy_i),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign busy = busy_i;
    assign idle = ~busy_i;

    assign r_in_range = ({1'b0, r_addr} < LIMIT);
    assign w_in_range = ({1'b0, w_addr} < LIMIT);
    assign r_acc      = idle & r_en;
    assign w_acc      = idle & w_en;
    assign w_ok       = w_acc & w_in_range & rst_n;

    assign rd_old  = r_in_range ? mem[r_addr] : '0;
    assign wr_old  = w_in_range ? mem[w_addr] : '0;
    assign wr_word = WORD_SIZE'(be_merge(MAX_WORD'(wr_old), MAX_WORD'(data_in),
                                         MAX_BYTES'(w_be)));

    // Same-address forwarding reuses the write merge, so lanes with be=0 keep the old data.
    always_comb begin
        rd_word = rd_old;
        if (BYPASS && w_ok && r_in_range && (w_addr == r_addr)) begin
            rd_word = wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (w_ok) begin
            mem[w_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            oob_err  <= 1'b0;
        end else begin
            rd_valid <= r_acc;
            oob_err  <= (r_acc & ~r_in_range) | (w_acc & ~w_in_range);
            if (r_acc) begin
                data_out <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_2p_sync.sv
// Directed bench: three instances share stimulus (BYPASS=1, BYPASS=0, MEM_SIZE=24).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_mem_2p_sync;

    logic        clk = 1'b0;
    logic        rst_n, clr, r_en, w_en;
    logic [4:0]  r_addr, w_addr;
    logic [3:0]  w_be;
    logic [31:0] data_in;

    logic        busy_a, rv_a, oob_a;
    logic        busy_b, rv_b, oob_b;
    logic        busy_c, rv_c, oob_c;
    logic [31:0] dout_a, dout_b, dout_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_2p_sync #(.ADDR_LEN(5), .WORD_SIZE(32), .MEM_SIZE(32), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
        .r_en(r_en), .r_addr(r_addr), .data_out(dout_a), .rd_valid(rv_a),
        .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .data_in(data_in), .oob_err(oob_a));

    mem_2p_sync #(.ADDR_LEN(5), .WORD_SIZE(32), .MEM_SIZE(32), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
        .r_en(r_en), .r_addr(r_addr), .data_out(dout_b), .rd_valid(rv_b),
        .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .data_in(data_in), .oob_err(oob_b));

    mem_2p_sync #(.ADDR_LEN(5), .WORD_SIZE(32), .MEM_SIZE(24), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_c),
        .r_en(r_en), .r_addr(r_addr), .data_out(dout_c), .rd_valid(rv_c),
        .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .data_in(data_in), .oob_err(oob_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        w_en = 1'b1; w_addr = a; data_in = d; w_be = be;
        tick();
        w_en = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a);
        r_en = 1'b1; r_addr = a;
        tick();
        r_en = 1'b0;
    endtask

    task automatic test_reset();
        int fall_a, fall_c, first_rv;
        rst_n = 1'b0; clr = 1'b0; r_en = 1'b0; w_en = 1'b0;
        r_addr = '0; w_addr = '0; w_be = '0; data_in = '0;
        tick(); tick();
        checks++;
        if (busy_a !== 1'b1 || rv_a !== 1'b0 || dout_a !== 32'h0 || oob_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rd_valid=%b data_out=%h oob=%b, want 1 0 0 0",
                     busy_a, rv_a, dout_a, oob_a);
        end
        rst_n = 1'b1; r_en = 1'b1; r_addr = 5'd0;
        fall_a = 0; fall_c = 0; first_rv = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (!busy_a && fall_a == 0) fall_a = n;
            if (!busy_c && fall_c == 0) fall_c = n;
            if (rv_a && first_rv == 0) first_rv = n;
        end
        checks++;
        if (fall_a !== 32) begin
            errors++;
            $display("FAIL reset_clear_len_32: busy fell after %0d cycles, want 32", fall_a);
        end
        checks++;
        if (fall_c !== 24) begin
            errors++;
            $display("FAIL reset_clear_len_24: busy fell after %0d cycles, want 24", fall_c);
        end
        checks++;
        if (first_rv !== 33) begin
            errors++;
            $display("FAIL first_read: first rd_valid after %0d cycles, want 33", first_rv);
        end
        for (int i = 0; i < 32; i++) begin
            r_addr = 5'(i);
            tick();
            checks++;
            if (rv_a !== 1'b1 || dout_a !== 32'h0) begin
                errors++;
                $display("FAIL reset_zero[%0d]: rd_valid=%b data_out=%h, want 1 00000000",
                         i, rv_a, dout_a);
            end
        end
        r_en = 1'b0;
        tick();
    endtask

    task automatic test_byte_enable();
        do_write(5'd3, 32'hDEADBEEF, 4'b1111);
        do_write(5'd3, 32'h000000AA, 4'b0001);
        do_read(5'd3);
        checks++;
        if (rv_a !== 1'b1 || dout_a !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL byte_enable: rd_valid=%b data_out=%h, want 1 deadbeaa", rv_a, dout_a);
        end
        tick();
        checks++;
        if (rv_a !== 1'b0 || dout_a !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL read_hold: rd_valid=%b data_out=%h, want 0 deadbeaa", rv_a, dout_a);
        end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h11111111, 4'b1111);
        w_en = 1'b1; w_addr = 5'd7; data_in = 32'h22222222; w_be = 4'b0011;
        r_en = 1'b1; r_addr = 5'd7;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        checks++;
        if (dout_a !== 32'h11112222) begin
            errors++;
            $display("FAIL bypass_on: data_out=%h, want 11112222", dout_a);
        end
        checks++;
        if (dout_b !== 32'h11111111) begin
            errors++;
            $display("FAIL bypass_off: data_out=%h, want 11111111", dout_b);
        end
        do_read(5'd7);
        checks++;
        if (dout_a !== 32'h11112222 || dout_b !== 32'h11112222) begin
            errors++;
            $display("FAIL write_visible: a=%h b=%h, want 11112222", dout_a, dout_b);
        end
        do_write(5'd7, 32'hFFFFFFFF, 4'b0000);
        checks++;
        if (oob_a !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_err: oob_err=%b, want 0", oob_a);
        end
        do_read(5'd7);
        checks++;
        if (dout_a !== 32'h11112222) begin
            errors++;
            $display("FAIL be_zero_data: data_out=%h, want 11112222", dout_a);
        end
    endtask

    task automatic test_oob();
        do_write(5'd30, 32'hFFFFFFFF, 4'b1111);
        checks++;
        if (oob_c !== 1'b1 || oob_a !== 1'b0) begin
            errors++;
            $display("FAIL oob_write: oob24=%b oob32=%b, want 1 0", oob_c, oob_a);
        end
        tick();
        checks++;
        if (oob_c !== 1'b0) begin
            errors++;
            $display("FAIL oob_pulse_len: oob_err=%b, want 0", oob_c);
        end
        do_read(5'd6);
        checks++;
        if (dout_c !== 32'h0) begin
            errors++;
            $display("FAIL oob_no_alias: mem[6]=%h, want 00000000", dout_c);
        end
        do_read(5'd23);
        checks++;
        if (dout_c !== 32'h0 || oob_c !== 1'b0) begin
            errors++;
            $display("FAIL oob_last_word: mem[23]=%h oob=%b, want 00000000 0", dout_c, oob_c);
        end
        do_read(5'd30);
        checks++;
        if (rv_c !== 1'b1 || dout_c !== 32'h0 || oob_c !== 1'b1) begin
            errors++;
            $display("FAIL oob_read: rd_valid=%b data_out=%h oob=%b, want 1 00000000 1",
                     rv_c, dout_c, oob_c);
        end
        checks++;
        if (dout_a !== 32'hFFFFFFFF || oob_a !== 1'b0) begin
            errors++;
            $display("FAIL inrange_30: data_out=%h oob=%b, want ffffffff 0", dout_a, oob_a);
        end
        w_en = 1'b1; w_addr = 5'd31; data_in = 32'h55555555; w_be = 4'b1111;
        r_en = 1'b1; r_addr = 5'd30;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        checks++;
        if (oob_c !== 1'b1) begin
            errors++;
            $display("FAIL oob_both: oob_err=%b, want 1", oob_c);
        end
        tick();
        checks++;
        if (oob_c !== 1'b0) begin
            errors++;
            $display("FAIL oob_both_single: oob_err=%b, want 0", oob_c);
        end
    endtask

    task automatic test_clear();
        int busy_obs, rv_err;
        for (int i = 0; i < 4; i++) do_write(5'(i), 32'hA0A0A0A0 + 32'(i), 4'b1111);
        clr = 1'b1; r_en = 1'b1; r_addr = 5'd2;
        tick();
        clr = 1'b0;
        checks++;
        if (rv_a !== 1'b1 || dout_a !== 32'hA0A0A0A2 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL clr_cycle_read: rd_valid=%b data_out=%h busy=%b, want 1 a0a0a0a2 1",
                     rv_a, dout_a, busy_a);
        end
        w_en = 1'b1; w_addr = 5'd5; data_in = 32'h12345678; w_be = 4'b1111;
        busy_obs = 1; rv_err = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!busy_a) break;
            busy_obs++;
            if (rv_a) rv_err++;
        end
        w_en = 1'b0; r_en = 1'b0;
        checks++;
        if (busy_obs !== 32) begin
            errors++;
            $display("FAIL clr_busy_len: busy for %0d cycles, want 32", busy_obs);
        end
        checks++;
        if (rv_err !== 0) begin
            errors++;
            $display("FAIL clr_reads_ignored: %0d rd_valid pulses while busy, want 0", rv_err);
        end
        for (int i = 0; i < 7; i++) begin
            logic [4:0] a;
            a = (i < 4) ? 5'(i) : (i == 4) ? 5'd5 : (i == 5) ? 5'd30 : 5'd31;
            do_read(a);
            checks++;
            if (rv_a !== 1'b1 || dout_a !== 32'h0) begin
                errors++;
                $display("FAIL clr_zero[%0d]: rd_valid=%b data_out=%h, want 1 00000000",
                         a, rv_a, dout_a);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        busy_obs = busy_a ? 1 : 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (!busy_a) break;
            busy_obs++;
        end
        checks++;
        if (busy_obs !== 32) begin
            errors++;
            $display("FAIL reset_mid_clear: busy for %0d cycles after reset, want 32", busy_obs);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) do_write(5'(i), 32'hCAFE0000 + 32'(i), 4'b1111);
        r_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_addr = 5'(i);
            tick();
            checks++;
            if (rv_a !== 1'b1 || dout_a !== (32'hCAFE0000 + 32'(i))) begin
                errors++;
                $display("FAIL back_to_back[%0d]: rd_valid=%b data_out=%h, want 1 %h",
                         i, rv_a, dout_a, 32'hCAFE0000 + 32'(i));
            end
        end
        r_en = 1'b0;
        tick();
        checks++;
        if (rv_a !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: rd_valid=%b, want 0", rv_a);
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_bypass();
        test_oob();
        test_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
